// File: rtl/instruction_fetch.sv
// Fetch stage: drives the boot ROM, buffers up to two PC-tagged instructions
// for decode, and handles branch redirects and out-of-range fetch faults.
module instruction_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] ROM_LAST = 32'h0000_005C
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] rom_address,
    output logic        rom_chip_select,
    output logic        rom_output_enable,
    input  logic [63:0] rom_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fault,
    output logic [1:0]  debug_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] fetch_pc;
    logic [1:0]  count;
    logic [31:0] head_word;
    logic [31:0] head_pc;
    logic [31:0] tail_word;
    logic [31:0] tail_pc;
    logic        issue;
    logic        pop;
    logic        in_range;
    logic        unused_rom_hi;

    assign unused_rom_hi = ^rom_data[63:32];
    assign in_range      = (fetch_pc <= ROM_LAST);

    // Handshake: an instruction transfers on a cycle where instr_valid and
    // instr_ready are both high; a redirect in that cycle cancels the transfer.
    assign instr_valid = (count != 2'd0);
    assign instr       = head_word;
    assign instr_pc    = head_pc;
    assign pop         = instr_valid && instr_ready && !redirect;

    assign rom_address       = fetch_pc;
    assign rom_chip_select   = issue;
    assign rom_output_enable = issue;
    assign fault             = (state == FAULT);
    assign debug_state       = state;

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE: state_next = RUN;
            RUN: begin
                if (redirect) begin
                    state_next = RUN;
                end else if (!in_range) begin
                    state_next = FAULT;
                end else begin
                    issue = (count < 2'd2) || (count == 2'd2 && instr_ready);
                end
            end
            FAULT: begin
                if (redirect) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= PC_RESET;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
        end else if (issue) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // Head is always entry 0; a pop shifts the tail forward so order is kept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count     <= 2'd0;
            head_word <= 32'd0;
            head_pc   <= 32'd0;
            tail_word <= 32'd0;
            tail_pc   <= 32'd0;
        end else if (redirect) begin
            count <= 2'd0;
        end else begin
            case ({issue, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_word <= rom_data[31:0];
                        head_pc   <= fetch_pc;
                    end else begin
                        tail_word <= rom_data[31:0];
                        tail_pc   <= fetch_pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_word <= tail_word;
                    head_pc   <= tail_pc;
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_word <= rom_data[31:0];
                        head_pc   <= fetch_pc;
                    end else begin
                        head_word <= tail_word;
                        head_pc   <= tail_pc;
                        tail_word <= rom_data[31:0];
                        tail_pc   <= fetch_pc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage between the program counter and the instruction decoder. It drives the boot ROM's address, chip-select and output-enable lines and captures the low 32 bits of the ROM data bus. It buffers up to two instructions, each tagged with its PC, and hands them to decode over a valid/ready handshake. Branch redirects and out-of-range fetches are handled here, so decode never sees a stale or undefined word.

## Interface
- PC_RESET, 32'h0000_0000, PC fetched first after reset.
- ROM_LAST, 32'h0000_005C, highest mapped instruction address; any fetch above it faults.

- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- rom_address  out  32  word address to ROM; equals fetch_pc
- rom_chip_select  out  1  high in every cycle a fetch is issued
- rom_output_enable  out  1  identical to rom_chip_select
- rom_data  in  64  ROM data bus; only [31:0] used
- redirect  in  1  branch taken; load redirect_pc
- redirect_pc  in  32  branch target; bits [1:0] forced to 0
- instr_valid  out  1  buffer head holds an instruction
- instr_ready  in  1  decode accepts head
- instr  out  32  head instruction
- instr_pc  out  32  PC of head instruction
- fault  out  1  fetch attempted above ROM_LAST

## Operation
- Reset, asynchronous with reset_n low, sets:
  - state=IDLE, fetch_pc=PC_RESET, buffer count=0
  - instr_valid=0, instr=0, instr_pc=0
  - rom_chip_select=0, rom_output_enable=0, fault=0
- States:
  - IDLE: unconditional move to RUN on the next edge. This is a dead cycle that lets the ROM address settle.
  - RUN: issues fetches.
  - FAULT: no fetches. Held until redirect.
- Fetch issue, in RUN only:
  - issue = !redirect && (count<2 || (count==2 && instr_valid && instr_ready)) && fetch_pc<=ROM_LAST.
  - The ROM is combinational on the address. rom_data[31:0] is sampled at the rising edge that ends the issue cycle and pushed with tag fetch_pc. fetch_pc then advances by 4.
- Fault: in RUN with fetch_pc>ROM_LAST and no redirect, the next state is FAULT and fault=1. The buffer contents stay and remain drainable.
- Buffer:
  - 2-entry FIFO.
  - Pop on instr_valid && instr_ready.
  - Simultaneous push and pop leaves count unchanged and keeps order.
  - A push into a full buffer happens only together with a pop.
- Redirect has priority over everything in RUN and in FAULT:
  - buffer flushed (count=0)
  - fetch_pc = {redirect_pc[31:2],2'b00}
  - fault cleared, state=RUN
  - no push or pop counted that cycle
- Redirect in IDLE: fetch_pc is loaded and the state moves to RUN as usual.
- PC arithmetic: 32-bit unsigned, wraps modulo 2^32. Overflow cannot reach a fetch while ROM_LAST < 32'hFFFF_FFFC.

## Timing
- rom_chip_select and rom_output_enable are combinational from state/count/redirect. Both are low whenever no fetch is issued.
- Reset-to-first-instruction:
  - reset_n rises before edge E0. E0: IDLE→RUN.
  - Cycle after E0: fetch of PC_RESET. E1 captures it.
  - instr_valid=1 after E1, instr_pc=PC_RESET.
- Steady state: one instruction per cycle while instr_ready is held high.
- Redirect latency:
  - Asserted in cycle C: instr_valid=0 after edge C.
  - The target is fetched in C+1 and is valid after edge C+1.
  - The instruction presented during C is consumed only if its pop is not counted (redirect wins), i.e. it is discarded.
- Backpressure: with instr_ready low and count==2, no fetch is issued, and instr and instr_pc stay stable.
- reset_n asserted mid-stream clears all state immediately. The buffered instructions are lost.

## Test plan
- Reset release, instr_ready=1, ROM image at 0x0000–0x005C -> instr_valid first high after E1 with instr=32'hB2001FE0, instr_pc=0. Then one word per cycle at PCs 0x4, 0x8, … in order.
- instr_ready=0 for 5 cycles after the first valid -> count reaches 2 and chip_select drops. instr holds 32'hB2001FE0. On release, PCs 0x0, 0x4, 0x8 are delivered with no gap or duplicate.
- Run to 0x005C with ROM_LAST=0x5C -> 0x5C is delivered (32'hD61F03E0 pattern per ROM), then fault=1 and no chip_select. Buffered words still drain.
- In FAULT, redirect=1 with redirect_pc=32'h0000_001F -> fault=0, next valid instr_pc=0x1C, instr=32'hF1003C9F.
- Redirect with count==2 and instr_ready=1 in the same cycle -> both entries discarded, instr_valid=0 next cycle, target valid one cycle later.
- reset_n pulsed low mid-stream with count==2 -> all outputs zero immediately, and the restart sequence matches the first scenario.
